decode_stage: RTL and testbench

Pipeline stage directly downstream of fetch. It latches the 16-bit instruction and its PC in an IF/ID register and decodes it into a registered ID/EX control bundle. It resolves unconditional jumps in decode by driving the fetch redirect (pcWrEn/newPc) and squashing the wrong-path instruction. It detects load-use hazards with a small scoreboard, then stalls fetch and inserts bubbles.

---
 rtl/asip_pkg.sv | 40 ++++
 rtl/load_scoreboard.sv | 49 ++++
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/asip_pkg.sv
// Shared definitions for the decode slice: opcode encodings, instruction
// field positions, default widths and the packed ID/EX bundle.
package asip_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned REG_W_DEF   = 4;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_VALU  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_MOVI  = 4'h5;
  localparam logic [3:0] OP_VLOAD = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;

  // Field LSB positions within the 16-bit instruction word.
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned FLD_W   = 4;
  localparam int unsigned IMM_W   = 8;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic       regwr;
    logic       memrd;
    logic       memwr;
    logic       isvec;
  } id_ex_t;

endpackage

// File: rtl/load_scoreboard.sv
// Load-use scoreboard: a DEPTH-deep shift register of {valid, rd} for loads
// that have issued but are not yet forwardable, plus source-match logic.
// Ports: clk/reset (sync, active-low); shift advances the pipe; push/rd is the
// shift-in entry; clear empties it; rs1/rs2 with enables are the query; hit
// flags a match against any valid entry.
module load_scoreboard
  import asip_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             push,
  input  logic [REG_W-1:0] rd,
  input  logic             clear,
  input  logic [REG_W-1:0] rs1,
  input  logic             rs1_en,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs2_en,
  output logic             hit
);

  logic [DEPTH-1:0] vld;
  logic [REG_W-1:0] dst [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      vld <= '0;
    end else if (shift) begin
      vld[0] <= push;
      dst[0] <= rd;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dst[i] <= dst[i-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i] && ((rs1_en && dst[i] == rs1) || (rs2_en && dst[i] == rs2)))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, instruction decode into a registered ID/EX
// bundle, decode-time jump redirect, and load-use stall via load_scoreboard.
// Ports: clk, reset (sync, active-low); instruction/fetchPc/fetchValid from
// fetch; exStall/exFlush from EX; pcWrEn/newPc redirect and fetchStall to
// fetch; id* outputs are the registered ID/EX bundle.
module decode_stage
  import asip_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [PC_W-1:0]    fetchPc,
  input  logic               fetchValid,
  input  logic               exStall,
  input  logic               exFlush,
  output logic               pcWrEn,
  output logic [PC_W-1:0]    newPc,
  output logic               fetchStall,
  output logic               idValid,
  output logic [3:0]         idOpcode,
  output logic [REG_W-1:0]   idRd,
  output logic [REG_W-1:0]   idRs1,
  output logic [REG_W-1:0]   idRs2,
  output logic [7:0]         idImm,
  output logic [PC_W-1:0]    idPc,
  output logic               idRegWr,
  output logic               idMemRd,
  output logic               idMemWr,
  output logic               idIsVector
);

  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  id_ex_t          dec;
  id_ex_t          ex_q;
  logic [PC_W-1:0] pc_q;
  logic            rd_rs1, rd_rs2;
  logic            hit, hazard, issue;

  always_comb begin
    dec        = '0;
    rd_rs1     = 1'b0;
    rd_rs2     = 1'b0;
    dec.valid  = 1'b1;
    dec.opcode = if_instr[OP_LSB +: FLD_W];
    dec.rd     = if_instr[RD_LSB +: FLD_W];
    dec.rs1    = if_instr[RS1_LSB +: FLD_W];
    dec.rs2    = if_instr[RS2_LSB +: FLD_W];
    dec.imm    = if_instr[IMM_LSB +: IMM_W];
    case (dec.opcode)
      OP_ALU, OP_VALU: begin
        dec.regwr = 1'b1;
        dec.isvec = (dec.opcode == OP_VALU);
        rd_rs1    = 1'b1;
        rd_rs2    = 1'b1;
      end
      OP_LOAD, OP_VLOAD: begin
        dec.regwr = 1'b1;
        dec.memrd = 1'b1;
        dec.isvec = (dec.opcode == OP_VLOAD);
        rd_rs1    = 1'b1;
      end
      OP_STORE: begin
        dec.memwr = 1'b1;
        rd_rs1    = 1'b1;
        rd_rs2    = 1'b1;
      end
      OP_MOVI: dec.regwr = 1'b1;
      default: ;
    endcase
  end

  load_scoreboard #(.DEPTH(LOAD_LAT), .REG_W(REG_W)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .shift  (~exStall),
    .push   (issue & dec.memrd),
    .rd     (REG_W'(dec.rd)),
    .clear  (exFlush),
    .rs1    (REG_W'(dec.rs1)),
    .rs1_en (rd_rs1),
    .rs2    (REG_W'(dec.rs2)),
    .rs2_en (rd_rs2),
    .hit    (hit)
  );

  assign hazard     = if_valid & hit;
  assign issue      = if_valid & ~hazard & ~exStall & ~exFlush;
  // Gated by reset so fetch sees no stall/redirect while reset is held.
  assign fetchStall = reset & (hazard | exStall);
  assign pcWrEn     = reset & if_valid & (dec.opcode == OP_JMP) &
                      ~hazard & ~exStall & ~exFlush;
  assign newPc      = PC_W'(dec.imm);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (exFlush || pcWrEn) begin
      if_valid <= 1'b0;
    end else if (!fetchStall) begin
      if_valid <= fetchValid;
      if_instr <= instruction;
      if_pc    <= fetchPc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q <= '0;
      pc_q <= '0;
    end else if (exFlush) begin
      ex_q.valid <= 1'b0;
    end else if (!exStall) begin
      if (issue) begin
        ex_q <= dec;
        pc_q <= if_pc;
      end else begin
        ex_q <= '0;
      end
    end
  end

  assign idValid    = ex_q.valid;
  assign idOpcode   = ex_q.opcode;
  assign idRd       = REG_W'(ex_q.rd);
  assign idRs1      = REG_W'(ex_q.rs1);
  assign idRs2      = REG_W'(ex_q.rs2);
  assign idImm      = ex_q.imm;
  assign idPc       = pc_q;
  assign idRegWr    = ex_q.regwr;
  assign idMemRd    = ex_q.memrd;
  assign idMemWr    = ex_q.memwr;
  assign idIsVector = ex_q.isvec;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam int LOAD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [7:0]  fetchPc;
  logic        fetchValid, exStall, exFlush;
  logic        pcWrEn, fetchStall, idValid;
  logic [7:0]  newPc, idImm, idPc;
  logic [3:0]  idOpcode, idRd, idRs1, idRs2;
  logic        idRegWr, idMemRd, idMemWr, idIsVector;

  decode_stage #(.PC_W(8), .INSTR_W(16), .REG_W(4), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .fetchPc(fetchPc),
    .fetchValid(fetchValid), .exStall(exStall), .exFlush(exFlush),
    .pcWrEn(pcWrEn), .newPc(newPc), .fetchStall(fetchStall),
    .idValid(idValid), .idOpcode(idOpcode), .idRd(idRd), .idRs1(idRs1),
    .idRs2(idRs2), .idImm(idImm), .idPc(idPc), .idRegWr(idRegWr),
    .idMemRd(idMemRd), .idMemWr(idMemWr), .idIsVector(idIsVector)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_ifv = 0;
  logic [15:0] m_ifi = '0;
  logic [7:0]  m_ifpc = '0;
  bit          e_valid = 0, e_ctl_known = 1;
  logic [3:0]  e_op, e_rd, e_rs1, e_rs2;
  logic [7:0]  e_imm, e_pc;
  bit          e_regwr, e_memrd, e_memwr, e_vec;
  int          pend_rd[$];
  int          pend_age[$];
  bit          c_haz, c_fs, c_pw;
  bit          obs_fs, obs_pw;
  logic [7:0]  obs_npc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input logic [3:0] r);
    foreach (pend_rd[i]) if (pend_rd[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    logic [3:0] op;
    bit r1, r2, cap;
    int nrd[$];
    int nage[$];
    @(negedge clk);
    op = m_ifi[15:12];
    r1 = (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h6});
    r2 = (op inside {4'h1, 4'h2, 4'h4});
    c_haz = m_ifv && ((r1 && busy(m_ifi[7:4])) || (r2 && busy(m_ifi[3:0])));
    c_fs = reset && (c_haz || exStall);
    c_pw = reset && m_ifv && op == 4'h7 && !c_haz && !exStall && !exFlush;
    obs_fs = fetchStall; obs_pw = pcWrEn; obs_npc = newPc;
    chk("fetchStall", 32'(fetchStall), 32'(c_fs));
    chk("pcWrEn", 32'(pcWrEn), 32'(c_pw));
    if (c_pw) chk("newPc", 32'(newPc), 32'(m_ifi[7:0]));
    @(posedge clk);
    if (!reset) begin
      m_ifv = 0; m_ifi = '0; m_ifpc = '0;
      e_valid = 0; e_ctl_known = 1;
      e_regwr = 0; e_memrd = 0; e_memwr = 0; e_vec = 0;
      pend_rd.delete(); pend_age.delete();
    end else begin
      cap = !exFlush && !exStall && m_ifv && !c_haz;
      if (exFlush) begin
        e_valid = 0; e_ctl_known = 0;
      end else if (!exStall) begin
        e_ctl_known = 1;
        e_regwr = 0; e_memrd = 0; e_memwr = 0; e_vec = 0;
        e_valid = cap;
        if (cap) begin
          e_op = op; e_rd = m_ifi[11:8]; e_rs1 = m_ifi[7:4]; e_rs2 = m_ifi[3:0];
          e_imm = m_ifi[7:0]; e_pc = m_ifpc;
          e_regwr = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6};
          e_memrd = op inside {4'h3, 4'h6};
          e_memwr = (op == 4'h4);
          e_vec   = op inside {4'h2, 4'h6};
        end
      end
      // Pending loads age once per non-stalled edge; retire at LOAD_LAT.
      if (exFlush) begin
        pend_rd.delete(); pend_age.delete();
      end else if (!exStall) begin
        foreach (pend_rd[i]) if (pend_age[i] + 1 < LOAD_LAT) begin
          nrd.push_back(pend_rd[i]); nage.push_back(pend_age[i] + 1);
        end
        pend_rd = nrd; pend_age = nage;
        if (cap && e_memrd) begin
          pend_rd.push_back(int'(e_rd)); pend_age.push_back(0);
        end
      end
      if (exFlush || c_pw) m_ifv = 0;
      else if (!c_fs) begin
        m_ifv = fetchValid; m_ifi = instruction; m_ifpc = fetchPc;
      end
    end
    #1;
    chk("idValid", 32'(idValid), 32'(e_valid));
    if (e_ctl_known) begin
      chk("idRegWr", 32'(idRegWr), 32'(e_regwr));
      chk("idMemRd", 32'(idMemRd), 32'(e_memrd));
      chk("idMemWr", 32'(idMemWr), 32'(e_memwr));
      chk("idIsVector", 32'(idIsVector), 32'(e_vec));
    end
    if (e_valid) begin
      chk("idOpcode", 32'(idOpcode), 32'(e_op));
      chk("idRd", 32'(idRd), 32'(e_rd));
      chk("idRs1", 32'(idRs1), 32'(e_rs1));
      chk("idRs2", 32'(idRs2), 32'(e_rs2));
      chk("idImm", 32'(idImm), 32'(e_imm));
      chk("idPc", 32'(idPc), 32'(e_pc));
    end
  endtask

  // Present a word and keep it up until decode accepts it; counts observed stalls.
  task automatic feed(input logic [15:0] w, input logic [7:0] pc, output int stalls);
    stalls = 0;
    instruction = w; fetchPc = pc; fetchValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (obs_fs) stalls++;
      if (!c_fs) return;
    end
    chk("feed_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] op;
    reset = 1'b0; instruction = 16'h1234; fetchPc = 8'h00; fetchValid = 1'b1;
    exStall = 1'b0; exFlush = 1'b0;

    // Reset held, then release
    cycle(); cycle();
    chk("rst_valid", 32'(idValid), 32'd0);
    reset = 1'b1;
    cycle(); cycle();
    chk("rst_op", 32'(idOpcode), 32'd1);
    chk("rst_rd", 32'(idRd), 32'd2);
    chk("rst_regwr", 32'(idRegWr), 32'd1);

    // Jump: one redirect, wrong-path word squashed
    feed(16'h7010, 8'h04, n);
    instruction = 16'h1111; fetchPc = 8'h05;
    cycle();
    chk("jmp_pw", 32'(obs_pw), 32'd1);
    chk("jmp_target", 32'(obs_npc), 32'h10);
    feed(16'h0000, 8'h10, n);
    feed(16'h0000, 8'h11, n);

    // Load-use: dependent ALU stalls LOAD_LAT cycles
    feed(16'h3520, 8'h20, n);
    feed(16'h1650, 8'h21, n);
    feed(16'h0000, 8'h22, n);
    chk("lu_stalls", 32'(n), 32'(LOAD_LAT));
    chk("lu_rs1", 32'(idRs1), 32'd5);
    feed(16'h3520, 8'h23, n);
    feed(16'h1670, 8'h24, n);
    feed(16'h0000, 8'h25, n);
    chk("nodep_stalls", 32'(n), 32'd0);

    // EX stall holds ID/EX
    feed(16'h1111, 8'h30, n);
    feed(16'h1222, 8'h31, n);
    exStall = 1'b1;
    repeat (3) cycle();
    chk("exs_pc", 32'(idPc), 32'h30);
    chk("exs_fs", 32'(obs_fs), 32'd1);
    exStall = 1'b0;
    feed(16'h0000, 8'h32, n);
    cycle();

    // Flush with a pending load and stall asserted
    feed(16'h3730, 8'h40, n);
    feed(16'h0000, 8'h41, n);
    exStall = 1'b1; exFlush = 1'b1;
    cycle();
    chk("fl_valid", 32'(idValid), 32'd0);
    exStall = 1'b0; exFlush = 1'b0;
    feed(16'h1170, 8'h42, n);
    feed(16'h0000, 8'h43, n);
    chk("fl_nostall", 32'(n), 32'd0);

    // Illegal opcode decodes as NOP with valid set
    feed(16'hF123, 8'h50, n);
    feed(16'h0000, 8'h51, n);
    chk("ill_valid", 32'(idValid), 32'd1);
    chk("ill_regwr", 32'(idRegWr), 32'd0);

    // Randomized traffic, small register set to provoke hazards
    for (int i = 0; i < 500; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      instruction = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      fetchPc    = 8'($urandom);
      fetchValid = ($urandom_range(0, 99) < 85);
      exStall    = ($urandom_range(0, 99) < 20);
      exFlush    = ($urandom_range(0, 99) < 5);
      reset      = ($urandom_range(0, 99) >= 2);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
